// File: rtl/bcd_ctrl_pkg.sv
// Shared types and BCD helpers for the multidecade counter controller.
package bcd_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  typedef logic [3:0] bcd_t;
  localparam bcd_t BCD_MAX = 4'd9;

  typedef struct packed {
    bcd_t hundred;
    bcd_t tens;
    bcd_t ones;
  } bcd3_t;

  function automatic logic bcd_valid(bcd3_t v);
    return (v.hundred <= BCD_MAX) && (v.tens <= BCD_MAX) && (v.ones <= BCD_MAX);
  endfunction

  // Value the counter will show after one increment (999 wraps to 000).
  function automatic bcd3_t bcd_inc(bcd3_t v);
    bcd3_t r;
    r = v;
    if (v.ones != BCD_MAX) r.ones = v.ones + 4'd1;
    else begin
      r.ones = '0;
      if (v.tens != BCD_MAX) r.tens = v.tens + 4'd1;
      else begin
        r.tens    = '0;
        r.hundred = (v.hundred == BCD_MAX) ? '0 : v.hundred + 4'd1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_counter_ctrl_prescaler.sv
// Free-running prescaler with freeze (i_en low holds value), sync clear and one-cycle tick.
module bcd_prescaler #(
  parameter int PRESCALE = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] r_cnt;

  assign o_tick = i_en && (r_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_cnt <= '0;
    else if (i_clr)  r_cnt <= '0;
    else if (i_en)   r_cnt <= o_tick ? '0 : r_cnt + 1'b1;
  end

endmodule

// File: rtl/bcd_counter_ctrl.sv
// Sequencer for the 3-digit BCD counter: run/pause/abort, target compare, auto-reload.
// Optional lap counter output enabled by defining BCD_CTRL_LAP_CNT_EN.
module bcd_counter_ctrl
  import bcd_ctrl_pkg::*;
#(
  parameter int PRESCALE = 10,
  parameter int LAP_W    = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic        abort,
  input  logic        auto_reload,
  input  logic [11:0] target_bcd,
  input  logic [3:0]  ones,
  input  logic [3:0]  tens,
  input  logic [3:0]  hundred,
  input  logic        cnt_done,
  output logic        cnt_enable,
  output logic        cnt_reset,
  output logic        busy,
  output logic        paused,
  output logic        match,
  output logic        err,
  output logic        wrap_seen
`ifdef BCD_CTRL_LAP_CNT_EN
  ,
  output logic [LAP_W-1:0] lap_count
`endif
);

  state_t r_state, w_next;
  bcd3_t  r_target, w_digits, w_tgt_in;
  logic   r_reload, r_stepped, r_cnt_enable, r_cnt_reset;
  logic   r_busy, r_paused, r_match, r_err, r_wrap;
  logic   w_tick, w_start_ok, w_accept, w_reject, w_match;

  assign w_digits   = {hundred, tens, ones};
  assign w_tgt_in   = target_bcd;
  assign w_start_ok = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && start && !abort;
  assign w_accept   = w_start_ok && bcd_valid(w_tgt_in);
  assign w_reject   = w_start_ok && !bcd_valid(w_tgt_in);
  // Compare the value the counter is about to take, so match lands with the digits
  // and no further enable is issued past the target (holds even at PRESCALE=1).
  assign w_match    = (r_state == ST_RUN) && !abort && r_stepped && r_cnt_enable &&
                      (bcd_inc(w_digits) == r_target);

  bcd_prescaler #(.PRESCALE(PRESCALE)) u_presc (
    .clk    (clk),
    .rst_n  (reset),
    .i_clr  (r_state == ST_CLEAR),
    .i_en   ((r_state == ST_RUN) && !stop && !abort),
    .o_tick (w_tick)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: if (w_accept) w_next = ST_CLEAR;
      ST_CLEAR:         w_next = ST_RUN;
      ST_RUN: begin
        if (w_match)   w_next = r_reload ? ST_CLEAR : ST_DONE;
        else if (stop) w_next = ST_PAUSE;
      end
      ST_PAUSE:         if (start && !stop) w_next = ST_RUN;
      default:          w_next = ST_IDLE;
    endcase
    if (abort) w_next = ST_IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_target     <= '0;
      r_reload     <= 1'b0;
      r_stepped    <= 1'b0;
      r_cnt_enable <= 1'b0;
      r_cnt_reset  <= 1'b1;
      r_busy       <= 1'b0;
      r_paused     <= 1'b0;
      r_match      <= 1'b0;
      r_err        <= 1'b0;
      r_wrap       <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_cnt_enable <= w_tick && (w_next == ST_RUN);
      r_cnt_reset  <= (w_next != ST_CLEAR);
      r_busy       <= (w_next == ST_CLEAR) || (w_next == ST_RUN) || (w_next == ST_PAUSE);
      r_paused     <= (w_next == ST_PAUSE);
      r_match      <= w_match;
      if (w_accept) begin
        r_target <= w_tgt_in;
        r_reload <= auto_reload;
      end
      if (r_state == ST_CLEAR)  r_stepped <= 1'b0;
      else if (w_tick)          r_stepped <= 1'b1;
      if (abort || w_accept)    r_err <= 1'b0;
      else if (w_reject)        r_err <= 1'b1;
      if (w_accept)             r_wrap <= 1'b0;
      else if (cnt_done && r_busy) r_wrap <= 1'b1;
    end
  end

  assign cnt_enable = r_cnt_enable;
  assign cnt_reset  = r_cnt_reset;
  assign busy       = r_busy;
  assign paused     = r_paused;
  assign match      = r_match;
  assign err        = r_err;
  assign wrap_seen  = r_wrap;

`ifdef BCD_CTRL_LAP_CNT_EN
  logic [LAP_W-1:0] r_lap;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                r_lap <= '0;
    else if (abort || w_accept)                r_lap <= '0;
    else if (w_match && r_reload && !(&r_lap)) r_lap <= r_lap + 1'b1;
  end

  assign lap_count = r_lap;
`endif

endmodule

// File: tb/tb_bcd_counter_ctrl.sv
// Directed bench: PRESCALE=2 controller plus a PRESCALE=1 instance for the full-wrap case.
module tb_bcd_counter_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        start = 0, stop = 0, abort = 0, auto_reload = 0;
  logic [11:0] target = '0;
  logic [11:0] cnt;
  logic        done, en, crst, busy, paused, match, err, wrap;
  logic        start1 = 0;
  logic [11:0] cnt1;
  logic        done1, en1, crst1, busy1, paused1, match1, err1, wrap1;
`ifdef BCD_CTRL_LAP_CNT_EN
  logic [7:0]  lap, lap1;
`endif

  int vec = 0;
  int errs = 0;

  bcd_counter_ctrl #(.PRESCALE(2), .LAP_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .abort(abort),
    .auto_reload(auto_reload), .target_bcd(target),
    .ones(cnt[3:0]), .tens(cnt[7:4]), .hundred(cnt[11:8]), .cnt_done(done),
    .cnt_enable(en), .cnt_reset(crst), .busy(busy), .paused(paused),
    .match(match), .err(err), .wrap_seen(wrap)
`ifdef BCD_CTRL_LAP_CNT_EN
    , .lap_count(lap)
`endif
  );

  bcd_counter_ctrl #(.PRESCALE(1), .LAP_W(8)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .stop(1'b0), .abort(1'b0),
    .auto_reload(1'b0), .target_bcd(12'h000),
    .ones(cnt1[3:0]), .tens(cnt1[7:4]), .hundred(cnt1[11:8]), .cnt_done(done1),
    .cnt_enable(en1), .cnt_reset(crst1), .busy(busy1), .paused(paused1),
    .match(match1), .err(err1), .wrap_seen(wrap1)
`ifdef BCD_CTRL_LAP_CNT_EN
    , .lap_count(lap1)
`endif
  );

  // Counter stand-in: decimal arithmetic, terminal count while stepping off 999.
  function automatic logic [11:0] tb_inc(logic [11:0] v);
    int n;
    n = int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
    n = (n + 1) % 1000;
    return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     cnt <= '0;
    else if (!crst) cnt <= '0;
    else if (en)    cnt <= tb_inc(cnt);
  end
  assign done = en && (cnt == 12'h999);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      cnt1 <= '0;
    else if (!crst1) cnt1 <= '0;
    else if (en1)    cnt1 <= tb_inc(cnt1);
  end
  assign done1 = en1 && (cnt1 == 12'h999);

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    repeat (2) step();
    vec++; if (en !== 1'b0)     begin errs++; $display("FAIL rst_en got=%b exp=0", en); end
    vec++; if (crst !== 1'b1)   begin errs++; $display("FAIL rst_cnt_reset got=%b exp=1", crst); end
    vec++; if (busy !== 1'b0)   begin errs++; $display("FAIL rst_busy got=%b exp=0", busy); end
    vec++; if (paused !== 1'b0) begin errs++; $display("FAIL rst_paused got=%b exp=0", paused); end
    vec++; if (match !== 1'b0)  begin errs++; $display("FAIL rst_match got=%b exp=0", match); end
    vec++; if (err !== 1'b0)    begin errs++; $display("FAIL rst_err got=%b exp=0", err); end
    vec++; if (wrap !== 1'b0)   begin errs++; $display("FAIL rst_wrap got=%b exp=0", wrap); end
    reset = 1'b1;
    step();
    vec++; if (busy !== 1'b0)   begin errs++; $display("FAIL post_rst_busy got=%b exp=0", busy); end
  endtask

  // Target 005, one-shot: enables at idx 3,5,7,9,11 and match at idx 12.
  task automatic test_oneshot;
    int n_en, first_en, last_en, m_idx, n_m, n_clr;
    logic [11:0] m_cnt;
    n_en = 0; first_en = -1; last_en = -1; m_idx = -1; n_m = 0; n_clr = 0; m_cnt = 'x;
    target = 12'h005; auto_reload = 1'b0; start = 1'b1;
    step(); start = 1'b0;
    vec++; if (crst !== 1'b0) begin errs++; $display("FAIL one_clear got=%b exp=0", crst); end
    vec++; if (busy !== 1'b1) begin errs++; $display("FAIL one_busy got=%b exp=1", busy); end
    for (int i = 0; i < 20; i++) begin
      if (!crst) n_clr++;
      if (en) begin n_en++; if (first_en < 0) first_en = i; last_en = i; end
      if (match) begin n_m++; if (m_idx < 0) begin m_idx = i; m_cnt = cnt; end end
      step();
    end
    vec++; if (n_clr !== 1)     begin errs++; $display("FAIL one_clr_len got=%0d exp=1", n_clr); end
    vec++; if (n_en !== 5)      begin errs++; $display("FAIL one_en_count got=%0d exp=5", n_en); end
    vec++; if (first_en !== 3)  begin errs++; $display("FAIL one_first_en got=%0d exp=3", first_en); end
    vec++; if (last_en !== 11)  begin errs++; $display("FAIL one_last_en got=%0d exp=11", last_en); end
    vec++; if (m_idx !== 12)    begin errs++; $display("FAIL one_match_idx got=%0d exp=12", m_idx); end
    vec++; if (n_m !== 1)       begin errs++; $display("FAIL one_match_count got=%0d exp=1", n_m); end
    vec++; if (m_cnt !== 12'h005) begin errs++; $display("FAIL one_match_digits got=%h exp=005", m_cnt); end
    vec++; if (busy !== 1'b0)   begin errs++; $display("FAIL one_done_busy got=%b exp=0", busy); end
    vec++; if (cnt !== 12'h005) begin errs++; $display("FAIL one_held got=%h exp=005", cnt); end
  endtask

  // Target 003 auto-reload: matches at idx 8,16,24, CLEAR at 0,8,16,24.
  task automatic test_reload;
    int n_m, n_clr, bad_digit;
    n_m = 0; n_clr = 0; bad_digit = 0;
    target = 12'h003; auto_reload = 1'b1; start = 1'b1;
    step(); start = 1'b0;
    for (int i = 0; i < 25; i++) begin
      if (!crst) n_clr++;
      if (match) begin n_m++; if (cnt !== 12'h003) bad_digit++; end
      step();
    end
    vec++; if (n_m !== 3)       begin errs++; $display("FAIL reload_matches got=%0d exp=3", n_m); end
    vec++; if (n_clr !== 4)     begin errs++; $display("FAIL reload_clears got=%0d exp=4", n_clr); end
    vec++; if (bad_digit !== 0) begin errs++; $display("FAIL reload_match_digits got=%0d bad exp=0", bad_digit); end
    vec++; if (cnt !== 12'h000) begin errs++; $display("FAIL reload_restart got=%h exp=000", cnt); end
    vec++; if (busy !== 1'b1)   begin errs++; $display("FAIL reload_busy got=%b exp=1", busy); end
`ifdef BCD_CTRL_LAP_CNT_EN
    vec++; if (lap !== 8'd3)    begin errs++; $display("FAIL reload_lap got=%0d exp=3", lap); end
`endif
    abort = 1'b1; step(); abort = 1'b0;
    vec++; if (busy !== 1'b0)   begin errs++; $display("FAIL reload_abort_busy got=%b exp=0", busy); end
`ifdef BCD_CTRL_LAP_CNT_EN
    vec++; if (lap !== 8'd0)    begin errs++; $display("FAIL reload_abort_lap got=%0d exp=0", lap); end
`endif
  endtask

  task automatic test_err;
    int act;
    logic seen;
    act = 0; seen = 1'b0;
    target = 12'h0A2; auto_reload = 1'b0; start = 1'b1;
    step(); start = 1'b0;
    vec++; if (err !== 1'b1)  begin errs++; $display("FAIL err_set got=%b exp=1", err); end
    vec++; if (busy !== 1'b0) begin errs++; $display("FAIL err_busy got=%b exp=0", busy); end
    for (int i = 0; i < 4; i++) begin
      if (!crst || en) act++;
      step();
    end
    vec++; if (act !== 0)     begin errs++; $display("FAIL err_activity got=%0d exp=0", act); end
    target = 12'h001; start = 1'b1;
    step(); start = 1'b0;
    vec++; if (err !== 1'b0)  begin errs++; $display("FAIL err_clear got=%b exp=0", err); end
    vec++; if (crst !== 1'b0) begin errs++; $display("FAIL err_restart got=%b exp=0", crst); end
    for (int i = 0; i < 6; i++) begin
      if (i == 4) seen = match;
      step();
    end
    vec++; if (seen !== 1'b1) begin errs++; $display("FAIL err_run_match got=%b exp=1", seen); end
    vec++; if (busy !== 1'b0) begin errs++; $display("FAIL err_run_done got=%b exp=0", busy); end
  endtask

  // Stop on the tick cycle at 002, resume after 20 cycles, then abort+stop together.
  task automatic test_stop_abort;
    int en_paused;
    en_paused = 0;
    target = 12'h005; auto_reload = 1'b0; start = 1'b1;
    step(); start = 1'b0;
    repeat (6) step();
    vec++; if (cnt !== 12'h002) begin errs++; $display("FAIL stop_pre_digits got=%h exp=002", cnt); end
    stop = 1'b1; step(); stop = 1'b0;
    vec++; if (en !== 1'b0)     begin errs++; $display("FAIL stop_suppress got=%b exp=0", en); end
    vec++; if (paused !== 1'b1) begin errs++; $display("FAIL stop_paused got=%b exp=1", paused); end
    for (int i = 0; i < 20; i++) begin
      if (en) en_paused++;
      step();
    end
    vec++; if (en_paused !== 0) begin errs++; $display("FAIL pause_en got=%0d exp=0", en_paused); end
    vec++; if (cnt !== 12'h002) begin errs++; $display("FAIL pause_digits got=%h exp=002", cnt); end
    start = 1'b1; step(); start = 1'b0;
    vec++; if (paused !== 1'b0) begin errs++; $display("FAIL resume_paused got=%b exp=0", paused); end
    vec++; if (en !== 1'b0)     begin errs++; $display("FAIL resume_en0 got=%b exp=0", en); end
    step();
    vec++; if (en !== 1'b1)     begin errs++; $display("FAIL resume_en1 got=%b exp=1", en); end
    step();
    vec++; if (cnt !== 12'h003) begin errs++; $display("FAIL resume_digits got=%h exp=003", cnt); end
    abort = 1'b1; stop = 1'b1; step(); abort = 1'b0; stop = 1'b0;
    vec++; if (busy !== 1'b0)   begin errs++; $display("FAIL abort_busy got=%b exp=0", busy); end
    vec++; if (paused !== 1'b0) begin errs++; $display("FAIL abort_paused got=%b exp=0", paused); end
    vec++; if (en !== 1'b0)     begin errs++; $display("FAIL abort_en got=%b exp=0", en); end
    repeat (3) step();
    vec++; if (cnt !== 12'h003) begin errs++; $display("FAIL abort_held got=%h exp=003", cnt); end
    vec++; if (crst !== 1'b1)   begin errs++; $display("FAIL abort_cnt_reset got=%b exp=1", crst); end
  endtask

  // PRESCALE=1, target 000: 1000 enables (idx 2..1001), match at idx 1002 after the wrap.
  task automatic test_wrap;
    int n_en, m_idx;
    logic w_mid, w_at_m;
    logic [11:0] m_cnt;
    n_en = 0; m_idx = -1; w_mid = 1'bx; w_at_m = 1'bx; m_cnt = 'x;
    start1 = 1'b1; step(); start1 = 1'b0;
    for (int i = 0; i < 1010; i++) begin
      if (en1) n_en++;
      if (i == 500) w_mid = wrap1;
      if (match1 && m_idx < 0) begin m_idx = i; m_cnt = cnt1; w_at_m = wrap1; end
      step();
    end
    vec++; if (n_en !== 1000)     begin errs++; $display("FAIL wrap_en_count got=%0d exp=1000", n_en); end
    vec++; if (w_mid !== 1'b0)    begin errs++; $display("FAIL wrap_early got=%b exp=0", w_mid); end
    vec++; if (m_idx !== 1002)    begin errs++; $display("FAIL wrap_match_idx got=%0d exp=1002", m_idx); end
    vec++; if (m_cnt !== 12'h000) begin errs++; $display("FAIL wrap_match_digits got=%h exp=000", m_cnt); end
    vec++; if (w_at_m !== 1'b1)   begin errs++; $display("FAIL wrap_seen got=%b exp=1", w_at_m); end
    vec++; if (busy1 !== 1'b0)    begin errs++; $display("FAIL wrap_done_busy got=%b exp=0", busy1); end
  endtask

  task automatic test_reset_midrun;
    target = 12'h009; auto_reload = 1'b0; start = 1'b1;
    step(); start = 1'b0;
    repeat (5) step();
    vec++; if (en !== 1'b1)     begin errs++; $display("FAIL mid_pre_en got=%b exp=1", en); end
    #2 reset = 1'b0;
    #1;
    vec++; if (en !== 1'b0)     begin errs++; $display("FAIL mid_en got=%b exp=0", en); end
    vec++; if (crst !== 1'b1)   begin errs++; $display("FAIL mid_cnt_reset got=%b exp=1", crst); end
    vec++; if (busy !== 1'b0)   begin errs++; $display("FAIL mid_busy got=%b exp=0", busy); end
    vec++; if (wrap1 !== 1'b0)  begin errs++; $display("FAIL mid_wrap got=%b exp=0", wrap1); end
    vec++; if (cnt !== 12'h000) begin errs++; $display("FAIL mid_digits got=%h exp=000", cnt); end
    @(posedge clk); #1 reset = 1'b1;
    step();
    vec++; if (busy !== 1'b0)   begin errs++; $display("FAIL mid_post_busy got=%b exp=0", busy); end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_reload();
    test_err();
    test_stop_abort();
    test_wrap();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
